// File: rtl/pkt_out_mux.sv
// Two-port packet merger: per-port data/metadata FIFOs with overflow dropping,
// packet-granular round-robin arbitration and a registered 520-bit output stream.
module pkt_out_mux #(
    parameter int unsigned DATA_DEPTH = 512,
    parameter int unsigned MD_DEPTH   = 16,
    parameter int unsigned ALF_MARGIN = 16
) (
    input  logic         clk,
    input  logic         aresetn,

    input  logic [519:0] a_pkt_in_data,
    input  logic         a_pkt_in_en,
    input  logic [255:0] a_pkt_in_md,
    input  logic         a_pkt_in_md_en,
    output logic         a_pkt_data_alf,

    input  logic [519:0] b_pkt_in_data,
    input  logic         b_pkt_in_en,
    input  logic [255:0] b_pkt_in_md,
    input  logic         b_pkt_in_md_en,
    output logic         b_pkt_data_alf,

    output logic [519:0] pkt_out_data,
    output logic         pkt_out_en,
    output logic [255:0] pkt_out_md,
    output logic         pkt_out_md_en,
    input  logic         pkt_out_alf,

    output logic [15:0]  a_drop_cnt,
    output logic [15:0]  b_drop_cnt
);

    localparam int unsigned DAW = $clog2(DATA_DEPTH);
    localparam int unsigned DPW = DAW + 1;
    localparam int unsigned MAW = $clog2(MD_DEPTH);
    localparam int unsigned MPW = MAW + 1;

    typedef enum logic [1:0] {StIdle, StSendA, StSendB} state_e;

    // Index 0 is port A, index 1 is port B.
    logic [519:0] w_in_data  [2];
    logic [255:0] w_in_md    [2];
    logic [1:0]   w_in_en;
    logic [1:0]   w_in_md_en;
    logic [1:0]   w_alf;
    logic [1:0]   w_data_empty;
    logic [1:0]   w_md_empty;
    logic [1:0]   w_pop_data;
    logic [1:0]   w_pop_md;
    logic [519:0] w_rd_word  [2];
    logic [255:0] w_rd_md    [2];
    logic [15:0]  w_drop_cnt [2];

    assign w_in_data[0]  = a_pkt_in_data;
    assign w_in_data[1]  = b_pkt_in_data;
    assign w_in_md[0]    = a_pkt_in_md;
    assign w_in_md[1]    = b_pkt_in_md;
    assign w_in_en       = {b_pkt_in_en, a_pkt_in_en};
    assign w_in_md_en    = {b_pkt_in_md_en, a_pkt_in_md_en};

    assign a_pkt_data_alf = w_alf[0];
    assign b_pkt_data_alf = w_alf[1];
    assign a_drop_cnt     = w_drop_cnt[0];
    assign b_drop_cnt     = w_drop_cnt[1];

    for (genvar g = 0; g < 2; g++) begin : g_port
        logic [519:0]   r_mem    [DATA_DEPTH];
        logic [255:0]   r_md_mem [MD_DEPTH];
        logic [DPW-1:0] r_wr_ptr;
        logic [DPW-1:0] r_rd_ptr;
        logic [DPW-1:0] r_pkt_start;
        logic [MPW-1:0] r_md_wr_ptr;
        logic [MPW-1:0] r_md_rd_ptr;
        logic           r_drop;
        logic           r_alf;
        logic [15:0]    r_drop_cnt;

        logic           w_full;
        logic           w_md_full;
        logic           w_head;
        logic           w_tail;
        logic           w_drop_now;
        logic           w_wr;
        logic           w_md_wr;
        logic [DPW-1:0] w_used;
        logic [DPW-1:0] w_free;

        assign w_full    = (r_wr_ptr[DAW] != r_rd_ptr[DAW]) &&
                           (r_wr_ptr[DAW-1:0] == r_rd_ptr[DAW-1:0]);
        assign w_md_full = (r_md_wr_ptr[MAW] != r_md_rd_ptr[MAW]) &&
                           (r_md_wr_ptr[MAW-1:0] == r_md_rd_ptr[MAW-1:0]);
        assign w_head    = ~w_in_data[g][519];
        assign w_tail    = ~w_in_data[g][518];

        // A tail whose metadata cannot be stored would leave an unmarked packet behind,
        // so it is treated like any other overflow.
        assign w_drop_now = w_in_en[g] &
                            (w_full | (r_drop & ~w_head) | (w_in_md_en[g] & w_tail & w_md_full));
        assign w_wr       = w_in_en[g] & ~w_drop_now;
        assign w_md_wr    = w_wr & w_in_md_en[g] & w_tail;
        assign w_used     = r_wr_ptr - r_rd_ptr;
        assign w_free     = DPW'(DATA_DEPTH) - w_used;

        always_ff @(posedge clk) begin
            if (w_wr) begin
                r_mem[r_wr_ptr[DAW-1:0]] <= w_in_data[g];
            end
            if (w_md_wr) begin
                r_md_mem[r_md_wr_ptr[MAW-1:0]] <= w_in_md[g];
            end
        end

        // On a drop the write pointer rewinds to the packet's head, so words of a
        // truncated packet are never visible to the reader.
        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_pkt_start <= '0;
                r_md_wr_ptr <= '0;
                r_md_rd_ptr <= '0;
                r_drop      <= 1'b0;
                r_alf       <= 1'b0;
                r_drop_cnt  <= '0;
            end else begin
                if (w_in_en[g]) begin
                    if (w_head) begin
                        r_pkt_start <= r_wr_ptr;
                    end
                    if (w_drop_now) begin
                        r_drop   <= 1'b1;
                        r_wr_ptr <= w_head ? r_wr_ptr : r_pkt_start;
                        if (r_drop_cnt != 16'hFFFF) begin
                            r_drop_cnt <= r_drop_cnt + 16'd1;
                        end
                    end else begin
                        r_wr_ptr <= r_wr_ptr + DPW'(1);
                        if (w_head) begin
                            r_drop <= 1'b0;
                        end
                    end
                end
                if (w_pop_data[g]) begin
                    r_rd_ptr <= r_rd_ptr + DPW'(1);
                end
                if (w_md_wr) begin
                    r_md_wr_ptr <= r_md_wr_ptr + MPW'(1);
                end
                if (w_pop_md[g]) begin
                    r_md_rd_ptr <= r_md_rd_ptr + MPW'(1);
                end
                r_alf <= (w_free <= DPW'(ALF_MARGIN)) | w_md_full;
            end
        end

        assign w_alf[g]        = r_alf;
        assign w_drop_cnt[g]   = r_drop_cnt;
        assign w_data_empty[g] = (r_wr_ptr == r_rd_ptr);
        assign w_md_empty[g]   = (r_md_wr_ptr == r_md_rd_ptr);
        assign w_rd_word[g]    = r_mem[r_rd_ptr[DAW-1:0]];
        assign w_rd_md[g]      = r_md_mem[r_md_rd_ptr[MAW-1:0]];
    end

    state_e       r_state;
    logic         r_rr_last;  // 0 = A served last, 1 = B served last
    logic [255:0] r_md;
    logic         r_first;

    logic         w_sel_b;
    logic         w_pick;
    logic         w_send;
    logic         w_cur;
    logic [519:0] w_word;

    always_comb begin
        if (!w_md_empty[0] && !w_md_empty[1]) begin
            w_sel_b = ~r_rr_last;
        end else begin
            w_sel_b = w_md_empty[0];
        end
        w_pick     = (r_state == StIdle) && !pkt_out_alf && (w_md_empty != 2'b11);
        w_cur      = (r_state == StSendB);
        w_send     = (r_state != StIdle) && !pkt_out_alf && !w_data_empty[w_cur];
        w_word     = w_rd_word[w_cur];
        w_pop_md   = {w_pick & w_sel_b, w_pick & ~w_sel_b};
        w_pop_data = {w_send & w_cur, w_send & ~w_cur};
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= StIdle;
            r_rr_last     <= 1'b1;
            r_md          <= '0;
            r_first       <= 1'b0;
            pkt_out_data  <= '0;
            pkt_out_en    <= 1'b0;
            pkt_out_md    <= '0;
            pkt_out_md_en <= 1'b0;
        end else begin
            pkt_out_en    <= w_send;
            pkt_out_md_en <= w_send & r_first;
            if (w_send) begin
                pkt_out_data <= w_word;
                if (r_first) begin
                    pkt_out_md <= r_md;
                end
            end
            case (r_state)
                StIdle: begin
                    if (w_pick) begin
                        r_state <= w_sel_b ? StSendB : StSendA;
                        r_md    <= w_rd_md[w_sel_b];
                        r_first <= 1'b1;
                    end
                end
                StSendA, StSendB: begin
                    if (w_send) begin
                        r_first <= 1'b0;
                        // Tags 10 and 00 both end a packet.
                        if (!w_word[518]) begin
                            r_rr_last <= w_cur;
                            r_state   <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_out_mux.sv
// Directed bench for pkt_out_mux: framing, arbitration order, backpressure,
// overflow dropping, single-word packets and reset mid-packet.
module tb_pkt_out_mux;

    localparam logic [255:0] MD_AA = {32{8'hAA}};
    localparam logic [255:0] MD_55 = {32{8'h55}};

    logic         clk = 1'b0;
    logic         aresetn;
    logic [519:0] a_pkt_in_data, b_pkt_in_data;
    logic         a_pkt_in_en, b_pkt_in_en;
    logic [255:0] a_pkt_in_md, b_pkt_in_md;
    logic         a_pkt_in_md_en, b_pkt_in_md_en;
    logic         a_pkt_data_alf, b_pkt_data_alf;
    logic [519:0] pkt_out_data;
    logic         pkt_out_en;
    logic [255:0] pkt_out_md;
    logic         pkt_out_md_en;
    logic         pkt_out_alf;
    logic [15:0]  a_drop_cnt, b_drop_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [519:0] data;
        logic [255:0] md;
        logic         md_en;
        int           cyc;
    } rec_t;
    rec_t q[$];

    pkt_out_mux dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .a_pkt_in_data  (a_pkt_in_data),
        .a_pkt_in_en    (a_pkt_in_en),
        .a_pkt_in_md    (a_pkt_in_md),
        .a_pkt_in_md_en (a_pkt_in_md_en),
        .a_pkt_data_alf (a_pkt_data_alf),
        .b_pkt_in_data  (b_pkt_in_data),
        .b_pkt_in_en    (b_pkt_in_en),
        .b_pkt_in_md    (b_pkt_in_md),
        .b_pkt_in_md_en (b_pkt_in_md_en),
        .b_pkt_data_alf (b_pkt_data_alf),
        .pkt_out_data   (pkt_out_data),
        .pkt_out_en     (pkt_out_en),
        .pkt_out_md     (pkt_out_md),
        .pkt_out_md_en  (pkt_out_md_en),
        .pkt_out_alf    (pkt_out_alf),
        .a_drop_cnt     (a_drop_cnt),
        .b_drop_cnt     (b_drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin : mon
        rec_t r;
        if (pkt_out_en === 1'b1) begin
            r.data  = pkt_out_data;
            r.md    = pkt_out_md;
            r.md_en = pkt_out_md_en;
            r.cyc   = cyc;
            q.push_back(r);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [519:0] mk(input logic [1:0] tag, input logic [31:0] v);
        return {tag, 6'd0, {16{v}}};
    endfunction

    function automatic logic [1:0] tag_of(input int i, input int n);
        if (n == 1) return 2'b00;
        if (i == 0) return 2'b01;
        if (i == n - 1) return 2'b10;
        return 2'b11;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int port, input logic [519:0] d, input logic en,
                            input logic [255:0] md, input logic md_en);
        if (port == 0) begin
            a_pkt_in_data = d; a_pkt_in_en = en; a_pkt_in_md = md; a_pkt_in_md_en = md_en;
        end else begin
            b_pkt_in_data = d; b_pkt_in_en = en; b_pkt_in_md = md; b_pkt_in_md_en = md_en;
        end
    endtask

    task automatic send_pkt(input int port, input int n, input logic [31:0] base,
                            input logic [255:0] md);
        for (int i = 0; i < n; i++) begin
            set_port(port, mk(tag_of(i, n), base + 32'(i)), 1'b1,
                     (i == n - 1) ? md : '0, i == n - 1);
            tick();
        end
        set_port(port, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_q(input int n, input int budget);
        for (int k = 0; k < budget && q.size() < n; k++) tick();
    endtask

    task automatic do_reset();
        set_port(0, '0, 1'b0, '0, 1'b0);
        set_port(1, '0, 1'b0, '0, 1'b0);
        pkt_out_alf = 1'b0;
        aresetn = 1'b0;
        tick(); tick();
        aresetn = 1'b1;
        tick();
        q.delete();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        set_port(0, '0, 1'b0, '0, 1'b0);
        set_port(1, '0, 1'b0, '0, 1'b0);
        pkt_out_alf = 1'b0;
        tick(); tick();
        checks++;
        if ({pkt_out_en, pkt_out_md_en} !== 2'b00) begin
            failures++; $display("FAIL reset_en: got %b expected 00", {pkt_out_en, pkt_out_md_en});
        end
        checks++;
        if (pkt_out_data !== '0 || pkt_out_md !== '0) begin
            failures++; $display("FAIL reset_data: got data %0h md %0h expected 0", pkt_out_data, pkt_out_md);
        end
        checks++;
        if ({a_pkt_data_alf, b_pkt_data_alf} !== 2'b00) begin
            failures++; $display("FAIL reset_alf: got %b expected 00", {a_pkt_data_alf, b_pkt_data_alf});
        end
        checks++;
        if (a_drop_cnt !== 16'd0 || b_drop_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_drop: got %0d/%0d expected 0/0", a_drop_cnt, b_drop_cnt);
        end
        aresetn = 1'b1;
        tick();
        q.delete();
    endtask

    task automatic test_single_a();
        int t_cyc;
        q.delete();
        send_pkt(0, 3, 32'hA000_0000, MD_AA);
        t_cyc = cyc;  // edge that wrote the tail and md
        wait_q(3, 50);
        repeat (5) tick();
        checks++;
        if (q.size() !== 3) begin
            failures++; $display("FAIL t1_count: got %0d words expected 3", q.size());
        end
        for (int i = 0; i < q.size() && i < 3; i++) begin
            checks++;
            if (q[i].data !== mk(tag_of(i, 3), 32'hA000_0000 + 32'(i))) begin
                failures++; $display("FAIL t1_data[%0d]: got %0h expected %0h", i, q[i].data,
                                     mk(tag_of(i, 3), 32'hA000_0000 + 32'(i)));
            end
            checks++;
            if (q[i].md_en !== (i == 0)) begin
                failures++; $display("FAIL t1_md_en[%0d]: got %b expected %b", i, q[i].md_en, i == 0);
            end
        end
        if (q.size() > 0) begin
            checks++;
            if (q[0].md !== MD_AA) begin
                failures++; $display("FAIL t1_md: got %0h expected %0h", q[0].md, MD_AA);
            end
            // Tail written at edge t: select at t+1, head popped and registered at t+2.
            checks++;
            if (q[0].cyc !== t_cyc + 2) begin
                failures++; $display("FAIL t1_latency: got edge %0d expected %0d", q[0].cyc, t_cyc + 2);
            end
        end
        if (q.size() == 3) begin
            checks++;
            if (q[2].cyc !== q[0].cyc + 2) begin
                failures++; $display("FAIL t1_contig: got span %0d expected 2", q[2].cyc - q[0].cyc);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] base [4];
        int          exp_cyc_gap;
        base[0] = 32'hA100_0000; base[1] = 32'hB100_0000;
        base[2] = 32'hA200_0000; base[3] = 32'hB200_0000;
        do_reset();
        pkt_out_alf = 1'b1;
        send_pkt(0, 2, base[0], MD_AA);
        send_pkt(1, 2, base[1], MD_55);
        send_pkt(0, 2, base[2], MD_AA);
        send_pkt(1, 2, base[3], MD_55);
        q.delete();
        pkt_out_alf = 1'b0;
        wait_q(8, 100);
        repeat (5) tick();
        checks++;
        if (q.size() !== 8) begin
            failures++; $display("FAIL t2_count: got %0d words expected 8", q.size());
        end
        for (int i = 0; i < q.size() && i < 8; i++) begin
            checks++;
            if (q[i].data !== mk(tag_of(i % 2, 2), base[i / 2] + 32'(i % 2))) begin
                failures++; $display("FAIL t2_order[%0d]: got %0h expected %0h", i, q[i].data,
                                     mk(tag_of(i % 2, 2), base[i / 2] + 32'(i % 2)));
            end
            if (i % 2 == 0) begin
                checks++;
                if (q[i].md_en !== 1'b1 || q[i].md !== ((i % 4 == 0) ? MD_AA : MD_55)) begin
                    failures++; $display("FAIL t2_md[%0d]: got en %b md %0h", i, q[i].md_en, q[i].md);
                end
            end
        end
        if (q.size() == 8) begin
            exp_cyc_gap = 2;  // one idle bubble between packets
            checks++;
            if (q[2].cyc - q[1].cyc !== exp_cyc_gap) begin
                failures++; $display("FAIL t2_bubble: got gap %0d expected %0d", q[2].cyc - q[1].cyc, exp_cyc_gap);
            end
        end
    endtask

    task automatic test_backpressure();
        q.delete();
        pkt_out_alf = 1'b1;
        send_pkt(0, 4, 32'hC000_0000, MD_AA);
        pkt_out_alf = 1'b0;
        tick(); tick(); tick();
        pkt_out_alf = 1'b1;
        repeat (5) tick();
        pkt_out_alf = 1'b0;
        wait_q(4, 50);
        repeat (10) tick();
        checks++;
        if (q.size() !== 4) begin
            failures++; $display("FAIL t3_count: got %0d words expected 4", q.size());
        end
        for (int i = 0; i < q.size() && i < 4; i++) begin
            checks++;
            if (q[i].data !== mk(tag_of(i, 4), 32'hC000_0000 + 32'(i))) begin
                failures++; $display("FAIL t3_data[%0d]: got %0h expected %0h", i, q[i].data,
                                     mk(tag_of(i, 4), 32'hC000_0000 + 32'(i)));
            end
        end
        if (q.size() == 4) begin
            // Five stalled cycles between words 1 and 2, none elsewhere.
            checks++;
            if (q[1].cyc - q[0].cyc !== 1 || q[2].cyc - q[1].cyc !== 6 || q[3].cyc - q[2].cyc !== 1) begin
                failures++; $display("FAIL t3_gaps: got %0d,%0d,%0d expected 1,6,1", q[1].cyc - q[0].cyc,
                                     q[2].cyc - q[1].cyc, q[3].cyc - q[2].cyc);
            end
        end
    endtask

    task automatic test_overflow_b();
        q.delete();
        for (int i = 0; i < 495; i++) begin
            set_port(1, mk((i == 0) ? 2'b01 : 2'b11, 32'hD000_0000 + 32'(i)), 1'b1, '0, 1'b0);
            tick();
        end
        set_port(1, '0, 1'b0, '0, 1'b0);
        tick();
        checks++;
        if (b_pkt_data_alf !== 1'b0) begin
            failures++; $display("FAIL t4_alf_495: got %b expected 0", b_pkt_data_alf);
        end
        set_port(1, mk(2'b11, 32'hD000_01EF), 1'b1, '0, 1'b0);
        tick();
        set_port(1, '0, 1'b0, '0, 1'b0);
        checks++;
        if (b_pkt_data_alf !== 1'b0) begin
            failures++; $display("FAIL t4_alf_same_cycle: got %b expected 0", b_pkt_data_alf);
        end
        tick();
        checks++;
        if (b_pkt_data_alf !== 1'b1) begin
            failures++; $display("FAIL t4_alf_496: got %b expected 1", b_pkt_data_alf);
        end
        for (int i = 0; i < 16; i++) begin
            set_port(1, mk(2'b11, 32'hD100_0000 + 32'(i)), 1'b1, '0, 1'b0);
            tick();
        end
        set_port(1, mk(2'b11, 32'hD200_0000), 1'b1, '0, 1'b0); tick();
        set_port(1, mk(2'b11, 32'hD200_0001), 1'b1, '0, 1'b0); tick();
        set_port(1, mk(2'b10, 32'hD200_0002), 1'b1, MD_55, 1'b1); tick();
        set_port(1, '0, 1'b0, '0, 1'b0);
        repeat (20) tick();
        checks++;
        if (b_drop_cnt !== 16'd3) begin
            failures++; $display("FAIL t4_drop_cnt: got %0d expected 3", b_drop_cnt);
        end
        checks++;
        if (a_drop_cnt !== 16'd0) begin
            failures++; $display("FAIL t4_a_drop: got %0d expected 0", a_drop_cnt);
        end
        checks++;
        if (q.size() !== 0) begin
            failures++; $display("FAIL t4_truncated_emitted: got %0d words expected 0", q.size());
        end
        send_pkt(1, 2, 32'hE000_0000, MD_55);
        wait_q(2, 50);
        repeat (5) tick();
        checks++;
        if (q.size() !== 2) begin
            failures++; $display("FAIL t4_next_count: got %0d words expected 2", q.size());
        end
        for (int i = 0; i < q.size() && i < 2; i++) begin
            checks++;
            if (q[i].data !== mk(tag_of(i, 2), 32'hE000_0000 + 32'(i))) begin
                failures++; $display("FAIL t4_next_data[%0d]: got %0h expected %0h", i, q[i].data,
                                     mk(tag_of(i, 2), 32'hE000_0000 + 32'(i)));
            end
        end
    endtask

    task automatic test_single_word_b();
        q.delete();
        send_pkt(1, 1, 32'hF000_0000, MD_AA);
        wait_q(1, 50);
        repeat (5) tick();
        checks++;
        if (q.size() !== 1) begin
            failures++; $display("FAIL t5_count: got %0d words expected 1", q.size());
        end
        if (q.size() > 0) begin
            checks++;
            if (q[0].data !== mk(2'b00, 32'hF000_0000) || q[0].md_en !== 1'b1 || q[0].md !== MD_AA) begin
                failures++; $display("FAIL t5_word: got %0h md_en %b md %0h", q[0].data, q[0].md_en, q[0].md);
            end
        end
    endtask

    task automatic test_reset_mid();
        q.delete();
        pkt_out_alf = 1'b1;
        send_pkt(0, 6, 32'h1000_0000, MD_55);
        send_pkt(0, 2, 32'h2000_0000, MD_AA);
        pkt_out_alf = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (pkt_out_en !== 1'b1) begin
            failures++; $display("FAIL t6_sending: got en %b expected 1", pkt_out_en);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if ({pkt_out_en, pkt_out_md_en} !== 2'b00 || pkt_out_data !== '0 || pkt_out_md !== '0) begin
            failures++; $display("FAIL t6_outputs: got en %b md_en %b data %0h md %0h expected 0",
                                 pkt_out_en, pkt_out_md_en, pkt_out_data, pkt_out_md);
        end
        checks++;
        if (b_drop_cnt !== 16'd0) begin
            failures++; $display("FAIL t6_drop_clear: got %0d expected 0", b_drop_cnt);
        end
        tick(); tick();
        aresetn = 1'b1;
        q.delete();
        repeat (30) tick();
        checks++;
        if (q.size() !== 0) begin
            failures++; $display("FAIL t6_residual: got %0d words expected 0", q.size());
        end
        checks++;
        if ({a_pkt_data_alf, b_pkt_data_alf} !== 2'b00) begin
            failures++; $display("FAIL t6_alf: got %b expected 00", {a_pkt_data_alf, b_pkt_data_alf});
        end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_round_robin();
        test_backpressure();
        test_overflow_b();
        test_single_word_b();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
